ctrl_fsm: RTL and testbench
===========================

Name: ctrl_fsm

Overview:
- Multi-cycle control unit that generates the datapath's control strobes: br, regdst, enable, alusrc, aluop, plus fetch and memory strobes.
- Decodes the 32-bit instruction held by the instruction memory and sequences FETCH/DECODE/EXEC/MEM/WB.
- Sits beside DATAPATH and replaces the constant values the bench drives today.
- MIPS-like subset: R-type add/sub/and/or/slt, plus lw, sw, beq, addi and halt.

Parameters:
- OPW, 6, opcode/funct field width.
- ALUW, 3, aluop width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  start strobe, sampled in IDLE.
- instr  in  32  instruction word from instruction memory.
- zero  in  1  ALU zero flag, sampled in EXEC of beq.
- br  out  1  branch: PC loads the branch target.
- regdst  out  1  write register: 1 = rd, 0 = rt.
- enable  out  1  register-file write enable.
- alusrc  out  1  ALU B operand: 1 = sign-extended immediate, 0 = rt.
- aluop  out  3  ALU operation code.
- pc_en  out  1  PC advances to PC+4.
- ir_load  out  1  latch instr.
- mem_rd  out  1  data memory read.
- mem_wr  out  1  data memory write.
- memtoreg  out  1  write-back source: 1 = memory, 0 = ALU.
- halted  out  1  halt reached, sticky.
- err  out  1  illegal opcode/funct, sticky.
- state_o  out  3  current state, for debug.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, TRAP=7.
- Reset (rst_n=0, async): state IDLE, every output 0, internal op/funct registers 0.
- All outputs are Moore: decoded from state and the latched op/funct registers only, never from instr or zero directly. The single exception is br, which also depends on zero in EXEC.
- IDLE: outputs 0. run=1 -> FETCH.
- FETCH: ir_load=1, pc_en=1. Next state DECODE.
- DECODE: op<=instr[31:26], funct<=instr[5:0], latched on the DECODE->next edge.
  - Opcode 111111 -> HALT.
  - Unknown opcode, or R-type with unknown funct -> TRAP.
  - Otherwise -> EXEC.
- aluop encoding: ADD=0, SUB=1, AND=2, OR=3, SLT=4, NOP=7.
  - R-type funct map: 100000->ADD, 100010->SUB, 100100->AND, 100101->OR, 101010->SLT.
- EXEC:
  - R-type: alusrc=0, aluop from funct. Next WB.
  - lw/sw (100011/101011): alusrc=1, aluop=ADD. Next MEM.
  - addi (001000): alusrc=1, aluop=ADD. Next WB.
  - beq (000100): alusrc=0, aluop=SUB, br=zero. Next FETCH.
- MEM:
  - lw: mem_rd=1. Next WB.
  - sw: mem_wr=1. Next FETCH.
- WB: enable=1 for one cycle only. Next FETCH.
  - R-type: regdst=1, memtoreg=0.
  - addi: regdst=0, memtoreg=0.
  - lw: regdst=0, memtoreg=1.
- Latency in cycles from FETCH entry: R-type 4, addi 4, lw 5, sw 4, beq 3, halt 2 (FETCH, DECODE, then HALT).
- HALT: halted=1, all strobes 0, stays until reset. run is ignored.
- TRAP: err=1, all strobes 0, stays until reset.
- Strobe exclusivity: at most one of enable / mem_wr / br high in any cycle, and mem_rd and mem_wr are never both high. Outputs are combinational decodes of registered state, so the spec treats them as glitch-tolerant.
- run is ignored outside IDLE; holding run high does not restart an instruction in flight.
- rst_n low mid-instruction: immediate return to IDLE, all strobes drop asynchronously, so no partial write completes after reset assertion.
- rst_n deassertion: synchronous to clk from the design's point of view; the first edge after release is evaluated in IDLE.

Decomposition:
- Package ctrl_pkg holds:
  - state encodings;
  - opcode constants: OP_RTYPE=000000, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_HALT=111111;
  - funct constants;
  - aluop constants.
- One sub-module, alu_dec: combinational mapping of (op, funct) to (aluop, legal).
  - Instantiated once.
  - Also used by DECODE for the TRAP decision.
- ctrl_fsm holds the state register, the op/funct registers and the output decode.

Test Plan:
- Reset then run=1 with instr=0x00221820 (add $3,$1,$2):
  - states 1,2,3,5 then 1;
  - EXEC: aluop=0, alusrc=0;
  - WB: enable=1, regdst=1, memtoreg=0;
  - pc_en=1 only in FETCH.
- instr=0x8C220004 (lw):
  - 5 cycles;
  - EXEC: alusrc=1, aluop=0;
  - MEM: mem_rd=1;
  - WB: enable=1, regdst=0, memtoreg=1.
- instr=0xAC220004 (sw):
  - MEM: mem_wr=1;
  - enable never high;
  - back to FETCH after 4 cycles.
- instr=0x10220002 (beq), zero=1 then rerun with zero=0:
  - EXEC: aluop=1, br=1 on the first run, br=0 on the second;
  - 3-cycle latency in both cases.
- instr=0x40000000 (illegal opcode 010000):
  - TRAP after DECODE, err=1, all strobes 0 for 10 cycles;
  - rst_n pulse returns to IDLE with err=0.
- instr=0xFC000000 (halt): halted=1, run pulses ignored.
- Reset mid-instruction: rst_n low during lw MEM -> mem_rd drops before the next clk edge and state_o=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle control unit.
//   - field widths (opcode/funct, aluop)
//   - FSM state encoding (visible on state_o for debug)
//   - opcode, funct and aluop constants of the supported MIPS-like subset
package ctrl_pkg;

  localparam int OPW  = 6;  // opcode / funct field width
  localparam int ALUW = 3;  // aluop width

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_HALT  = 6'b111111;

  // R-type funct codes (instr[5:0])
  localparam logic [OPW-1:0] FN_ADD = 6'b100000;
  localparam logic [OPW-1:0] FN_SUB = 6'b100010;
  localparam logic [OPW-1:0] FN_AND = 6'b100100;
  localparam logic [OPW-1:0] FN_OR  = 6'b100101;
  localparam logic [OPW-1:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [ALUW-1:0] ALU_ADD = 3'd0;
  localparam logic [ALUW-1:0] ALU_SUB = 3'd1;
  localparam logic [ALUW-1:0] ALU_AND = 3'd2;
  localparam logic [ALUW-1:0] ALU_OR  = 3'd3;
  localparam logic [ALUW-1:0] ALU_SLT = 3'd4;
  localparam logic [ALUW-1:0] ALU_NOP = 3'd7;

  // Instructions whose ALU B operand is the sign-extended immediate.
  function automatic logic uses_imm(input logic [OPW-1:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/ctrl_fsm_alu_dec.sv
// alu_dec: combinational decode of (op, funct) into the ALU operation
// and a legality flag for the supported subset.
//   op     in  opcode field
//   funct  in  funct field (only meaningful for R-type)
//   aluop  out ALU operation code (NOP when illegal)
//   legal  out 1 when op/funct is an executable instruction
// The halt opcode is reported as not legal here; the FSM tests it first.
module alu_dec
  import ctrl_pkg::*;
(
  input  logic [OPW-1:0]  op,
  input  logic [OPW-1:0]  funct,
  output logic [ALUW-1:0] aluop,
  output logic            legal
);

  always_comb begin
    aluop = ALU_NOP;
    legal = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin aluop = ALU_ADD; legal = 1'b1; end
          FN_SUB:  begin aluop = ALU_SUB; legal = 1'b1; end
          FN_AND:  begin aluop = ALU_AND; legal = 1'b1; end
          FN_OR:   begin aluop = ALU_OR;  legal = 1'b1; end
          FN_SLT:  begin aluop = ALU_SLT; legal = 1'b1; end
          default: begin aluop = ALU_NOP; legal = 1'b0; end
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: begin
        aluop = ALU_ADD;  // address / immediate add
        legal = 1'b1;
      end
      OP_BEQ: begin
        aluop = ALU_SUB;  // compare by subtraction, ALU raises zero
        legal = 1'b1;
      end
      default: begin
        aluop = ALU_NOP;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle control unit for the MIPS-like datapath.
// Sequences IDLE -> FETCH -> DECODE -> EXEC [-> MEM] [-> WB] -> FETCH,
// with HALT and TRAP as terminal states left only through reset.
//   clk       in  system clock, rising edge
//   rst_n     in  asynchronous active-low reset
//   run       in  start strobe, only honoured in IDLE
//   instr     in  instruction word, decoded during DECODE
//   zero      in  ALU zero flag, used for beq in EXEC
//   br        out PC loads branch target
//   regdst    out write register select (1 = rd, 0 = rt)
//   enable    out register-file write enable
//   alusrc    out ALU B select (1 = immediate, 0 = rt)
//   aluop     out ALU operation code
//   pc_en     out PC <= PC+4
//   ir_load   out latch instruction register
//   mem_rd    out data memory read
//   mem_wr    out data memory write
//   memtoreg  out write-back source (1 = memory, 0 = ALU)
//   halted    out halt reached (sticky until reset)
//   err       out illegal instruction seen (sticky until reset)
//   state_o   out current state, for debug
// All outputs decode the registered state and latched op/funct only, so
// they drop together with the asynchronous reset. br additionally follows
// zero while in EXEC.
module ctrl_fsm
  import ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [31:0]     instr,
  input  logic            zero,
  output logic            br,
  output logic            regdst,
  output logic            enable,
  output logic            alusrc,
  output logic [ALUW-1:0] aluop,
  output logic            pc_en,
  output logic            ir_load,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            memtoreg,
  output logic            halted,
  output logic            err,
  output logic [2:0]      state_o
);

  state_t         state, state_next;
  logic [OPW-1:0] op_reg, funct_reg;

  logic [OPW-1:0]  dec_op, dec_funct;
  logic [ALUW-1:0] dec_aluop;
  logic            dec_legal;

  // Register fields between the opcode and funct are not used here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:6];

  // A single decoder serves both phases: in DECODE it looks at the live
  // instruction word for the TRAP decision, afterwards at the latched copy
  // so that EXEC outputs never depend on instr directly.
  assign dec_op    = (state == S_DECODE) ? instr[31:26] : op_reg;
  assign dec_funct = (state == S_DECODE) ? instr[5:0]   : funct_reg;

  alu_dec u_alu_dec (
    .op    (dec_op),
    .funct (dec_funct),
    .aluop (dec_aluop),
    .legal (dec_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_reg    <= '0;
      funct_reg <= '0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) begin
        op_reg    <= instr[31:26];
        funct_reg <= instr[5:0];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   state_next = run ? S_FETCH : S_IDLE;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if (dec_op == OP_HALT)
          state_next = S_HALT;
        else if (!dec_legal)
          state_next = S_TRAP;
        else
          state_next = S_EXEC;
      end
      S_EXEC: begin
        if (op_reg == OP_LW || op_reg == OP_SW)
          state_next = S_MEM;
        else if (op_reg == OP_BEQ)
          state_next = S_FETCH;
        else
          state_next = S_WB;  // R-type, addi
      end
      S_MEM:    state_next = (op_reg == OP_LW) ? S_WB : S_FETCH;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    br       = 1'b0;
    regdst   = 1'b0;
    enable   = 1'b0;
    alusrc   = 1'b0;
    aluop    = '0;
    pc_en    = 1'b0;
    ir_load  = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    memtoreg = 1'b0;
    halted   = 1'b0;
    err      = 1'b0;
    case (state)
      S_FETCH: begin
        ir_load = 1'b1;
        pc_en   = 1'b1;
      end
      S_EXEC: begin
        aluop  = dec_aluop;
        alusrc = uses_imm(op_reg);
        br     = (op_reg == OP_BEQ) && zero;
      end
      S_MEM: begin
        mem_rd = (op_reg == OP_LW);
        mem_wr = (op_reg == OP_SW);
      end
      S_WB: begin
        enable   = 1'b1;
        regdst   = (op_reg == OP_RTYPE);
        memtoreg = (op_reg == OP_LW);
      end
      S_HALT:  halted = 1'b1;
      S_TRAP:  err    = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_ctrl_fsm.sv
module tb_ctrl_fsm;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [31:0] instr;
  logic        zero;
  logic        br, regdst, enable, alusrc, pc_en, ir_load;
  logic        mem_rd, mem_wr, memtoreg, halted, err;
  logic [2:0]  aluop;
  logic [2:0]  state_o;

  ctrl_fsm dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .instr    (instr),
    .zero     (zero),
    .br       (br),
    .regdst   (regdst),
    .enable   (enable),
    .alusrc   (alusrc),
    .aluop    (aluop),
    .pc_en    (pc_en),
    .ir_load  (ir_load),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .memtoreg (memtoreg),
    .halted   (halted),
    .err      (err),
    .state_o  (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed output vector, one field per DUT output
  typedef struct packed {
    logic [2:0] st;
    logic       br, regdst, enable, alusrc;
    logic [2:0] aluop;
    logic       pc_en, ir_load, mem_rd, mem_wr, memtoreg, halted, err;
  } obs_t;

  obs_t obs;
  assign obs = {state_o, br, regdst, enable, alusrc, aluop,
                pc_en, ir_load, mem_rd, mem_wr, memtoreg, halted, err};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Strobe exclusivity, every cycle out of reset
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ((int'(enable) + int'(mem_wr) + int'(br)) > 1 || (mem_rd && mem_wr)) begin
        errors++;
        $display("FAIL exclusivity: en=%0b wr=%0b br=%0b rd=%0b required at most one", enable, mem_wr, br, mem_rd);
      end
    end
  end

  // Reference model: per-cycle expected outputs from FETCH entry, derived
  // from the instruction class rules.
  obs_t exp_q[$];

  task automatic build_exp(input logic [31:0] ins, input logic z);
    obs_t o;
    logic [5:0] op, fn;
    logic [2:0] fa;
    logic fok;
    exp_q.delete();
    op = ins[31:26];
    fn = ins[5:0];
    o = '0; o.st = 3'd1; o.pc_en = 1'b1; o.ir_load = 1'b1; exp_q.push_back(o);
    o = '0; o.st = 3'd2; exp_q.push_back(o);
    fok = 1'b1;
    case (fn)
      6'h20:   fa = 3'd0;
      6'h22:   fa = 3'd1;
      6'h24:   fa = 3'd2;
      6'h25:   fa = 3'd3;
      6'h2A:   fa = 3'd4;
      default: begin fa = 3'd7; fok = 1'b0; end
    endcase
    if (op == 6'h3F) begin
      o = '0; o.st = 3'd6; o.halted = 1'b1;
      repeat (6) exp_q.push_back(o);
    end else if (op == 6'h00 && fok) begin
      o = '0; o.st = 3'd3; o.aluop = fa; exp_q.push_back(o);
      o = '0; o.st = 3'd5; o.enable = 1'b1; o.regdst = 1'b1; exp_q.push_back(o);
    end else if (op == 6'h23) begin
      o = '0; o.st = 3'd3; o.alusrc = 1'b1; exp_q.push_back(o);
      o = '0; o.st = 3'd4; o.mem_rd = 1'b1; exp_q.push_back(o);
      o = '0; o.st = 3'd5; o.enable = 1'b1; o.memtoreg = 1'b1; exp_q.push_back(o);
    end else if (op == 6'h2B) begin
      o = '0; o.st = 3'd3; o.alusrc = 1'b1; exp_q.push_back(o);
      o = '0; o.st = 3'd4; o.mem_wr = 1'b1; exp_q.push_back(o);
    end else if (op == 6'h04) begin
      o = '0; o.st = 3'd3; o.aluop = 3'd1; o.br = z; exp_q.push_back(o);
    end else if (op == 6'h08) begin
      o = '0; o.st = 3'd3; o.alusrc = 1'b1; exp_q.push_back(o);
      o = '0; o.st = 3'd5; o.enable = 1'b1; exp_q.push_back(o);
    end else begin
      o = '0; o.st = 3'd7; o.err = 1'b1;
      repeat (10) exp_q.push_back(o);
    end
  endtask

  // Entered at the sampling point of a FETCH cycle; returns at the sampling
  // point of the next FETCH (lat = cycles taken) or, for terminal states,
  // after the modelled cycles with lat = -1.
  task automatic run_instr(input logic [31:0] ins, input logic z, output int lat,
                           output logic [2:0] ex_aluop, output logic ex_br);
    int n;
    instr = ins;
    zero  = z;
    build_exp(ins, z);
    n = exp_q.size();
    lat = -1;
    ex_aluop = 3'd0;
    ex_br = 1'b0;
    for (int c = 0; c <= n; c++) begin
      if (c > 0) @(negedge clk);
      if (c > 0 && state_o == 3'd1) begin
        lat = c;
        break;
      end
      if (c < n) check($sformatf("cyc%0d_%08h", c, ins), 32'(obs), 32'(exp_q[c]));
      if (state_o == 3'd3) begin
        ex_aluop = aluop;
        ex_br = br;
      end
      // Once latched, the instruction word and zero (outside EXEC) must not matter
      if (c >= 2) begin
        #1;
        instr = $urandom;
        if (c >= 3) zero = 1'($urandom);
      end
    end
  endtask

  task automatic start_run();
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b0;
    @(negedge clk);
    check("idle_hold", 32'(state_o), 32'd0);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check("run_to_fetch", 32'(state_o), 32'd1);
  endtask

  typedef struct {
    logic [31:0] ins;
    logic        z;
    int          lat;
    logic [2:0]  aluop;
    logic        br;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [2:0] ea;
    logic eb;
    logic [31:0] ins;
    logic [5:0] fns[5];
    logic [31:0] mid;
    logic z;

    tbl[0] = '{32'h00221820, 1'b0, 4, 3'd0, 1'b0};  // add
    tbl[1] = '{32'h00221822, 1'b0, 4, 3'd1, 1'b0};  // sub
    tbl[2] = '{32'h00221824, 1'b1, 4, 3'd2, 1'b0};  // and
    tbl[3] = '{32'h00221825, 1'b0, 4, 3'd3, 1'b0};  // or
    tbl[4] = '{32'h0022182A, 1'b0, 4, 3'd4, 1'b0};  // slt
    tbl[5] = '{32'h8C220004, 1'b0, 5, 3'd0, 1'b0};  // lw
    tbl[6] = '{32'hAC220004, 1'b1, 4, 3'd0, 1'b0};  // sw
    tbl[7] = '{32'h10220002, 1'b1, 3, 3'd1, 1'b1};  // beq taken
    tbl[8] = '{32'h10220002, 1'b0, 3, 3'd1, 1'b0};  // beq not taken
    tbl[9] = '{32'h20220005, 1'b1, 4, 3'd0, 1'b0};  // addi
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;

    rst_n = 1'b1;
    run = 1'b0;
    instr = 32'h0;
    zero = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("reset_obs", 32'(obs), 32'd0);
    run = 1'b1;
    @(negedge clk);
    check("reset_ignores_run", 32'(obs), 32'd0);
    start_run();

    // Table-driven pass
    for (int i = 0; i < 10; i++) begin
      run_instr(tbl[i].ins, tbl[i].z, lat, ea, eb);
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
      check($sformatf("tbl%0d_aluop", i), 32'(ea), 32'(tbl[i].aluop));
      check($sformatf("tbl%0d_br", i), 32'(eb), 32'(tbl[i].br));
      $display("tbl  instr=%08h zero=%0b lat=%0d aluop=%0d br=%0b", tbl[i].ins, tbl[i].z, lat, ea, eb);
    end

    // Randomized legal instructions; run toggles freely (must be ignored)
    for (int i = 0; i < 40; i++) begin
      mid = $urandom;
      z = 1'($urandom);
      case ($urandom_range(0, 4))
        0:       ins = {6'h00, mid[19:0], fns[$urandom_range(0, 4)]};
        1:       ins = {6'h23, mid[25:0]};
        2:       ins = {6'h2B, mid[25:0]};
        3:       ins = {6'h04, mid[25:0]};
        default: ins = {6'h08, mid[25:0]};
      endcase
      run = 1'($urandom);
      run_instr(ins, z, lat, ea, eb);
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(exp_q.size()));
      $display("rnd  instr=%08h zero=%0b lat=%0d aluop=%0d br=%0b", ins, z, lat, ea, eb);
    end
    run = 1'b0;

    // Reset during lw MEM: strobes drop before the next clock edge
    instr = 32'h8C220004;
    zero = 1'b0;
    repeat (3) @(negedge clk);
    check("lw_mem_rd_before_reset", 32'({state_o, mem_rd}), 32'({3'd4, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    check("midreset_mem_rd", 32'(mem_rd), 32'd0);
    check("midreset_obs", 32'(obs), 32'd0);
    $display("seq  reset during lw MEM state=%0d mem_rd=%0b", state_o, mem_rd);
    start_run();

    // Illegal opcode -> TRAP, then reset clears err
    run_instr(32'h40000000, 1'b0, lat, ea, eb);
    check("trap_op_no_return", 32'(lat), 32'hFFFFFFFF);
    #2 rst_n = 1'b0;
    #1;
    check("trap_reset_obs", 32'(obs), 32'd0);
    $display("seq  illegal opcode trap then reset err=%0b", err);
    start_run();

    // Illegal R-type funct -> TRAP
    run_instr(32'h0022183F, 1'b1, lat, ea, eb);
    check("trap_funct_no_return", 32'(lat), 32'hFFFFFFFF);
    #2 rst_n = 1'b0;
    #1;
    check("trap_funct_reset_err", 32'(err), 32'd0);
    $display("seq  illegal funct trap then reset err=%0b", err);
    start_run();

    // HALT with run held high, then run pulses
    run = 1'b1;
    run_instr(32'hFC000000, 1'b0, lat, ea, eb);
    check("halt_no_return", 32'(lat), 32'hFFFFFFFF);
    for (int i = 0; i < 4; i++) begin
      run = ~run;
      @(negedge clk);
      check($sformatf("halt_sticky%0d", i), 32'({state_o, halted}), 32'({3'd6, 1'b1}));
    end
    $display("seq  halt sticky state=%0d halted=%0b", state_o, halted);
    run = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
